// File: rtl/sigma_delta_pkg.sv
// Shared widths and the fixed-point gain helper for the two-piece
// magic-circle oscillator.
package sigma_delta_pkg;

  localparam int DEF_BITWIDTH = 40;
  localparam int DEF_KFRAC    = 32;
  localparam int MAXW         = 64;

  // Wide enough for any BITWIDTH up to MAXW; callers sign-extend acc,
  // zero-extend k and truncate the result back to their own width.
  function automatic logic signed [MAXW-1:0] scale_mult(
    input logic signed [MAXW-1:0] acc,
    input logic        [MAXW-1:0] k,
    input int                     kfrac
  );
    logic signed [2*MAXW:0] prod;
    prod = (2*MAXW+1)'($signed({1'b0, k})) * (2*MAXW+1)'(acc);
    return MAXW'(prod >>> kfrac);
  endfunction

endpackage

// File: rtl/sd_piece.sv
// One resonator piece: k-gain multiplier, wrapping integrator and a
// first-order sigma-delta modulator driven by the registered integrator.
module sd_piece
  import sigma_delta_pkg::*;
#(
  parameter int                         BITWIDTH  = DEF_BITWIDTH,
  parameter int                         KFRAC     = DEF_KFRAC,
  parameter logic signed [BITWIDTH-1:0] INIT      = '0,
  parameter bit                         SUBTRACT  = 1'b0,
  parameter bit                         FEED_NEXT = 1'b0,
  parameter logic signed [BITWIDTH+1:0] FS        = (BITWIDTH+2)'(1) << (BITWIDTH-2)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic        [BITWIDTH-1:0] i_kin,
  input  logic signed [BITWIDTH-1:0] i_mult,
  output logic signed [BITWIDTH-1:0] o_feed,
  output logic                       o_sd
);

  logic signed [BITWIDTH-1:0] gained;
  logic signed [BITWIDTH-1:0] acc;
  logic signed [BITWIDTH-1:0] w_acc_next;
  logic signed [BITWIDTH+1:0] r_err;
  logic signed [BITWIDTH+1:0] w_v;
  logic signed [BITWIDTH+1:0] w_fb;
  logic                       r_sd;

  assign gained     = BITWIDTH'(scale_mult(MAXW'(i_mult), MAXW'(i_kin), KFRAC));
  assign w_acc_next = SUBTRACT ? acc - gained : acc + gained;

  // The modulator sees the integrator value from before this cycle's update.
  assign w_v  = (BITWIDTH+2)'(acc) + r_err;
  assign w_fb = w_v[BITWIDTH+1] ? -FS : FS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= INIT;
      r_err <= '0;
      r_sd  <= 1'b0;
    end else begin
      acc   <= w_acc_next;
      r_err <= w_v - w_fb;
      r_sd  <= ~w_v[BITWIDTH+1];
    end
  end

  // The cosine piece hands its freshly updated value on; that ordering keeps
  // the oscillation amplitude bounded.
  assign o_feed = FEED_NEXT ? w_acc_next : acc;
  assign o_sd   = r_sd;

endmodule

// File: rtl/sigma_delta_two_piece_top.sv
// Quadrature tone generator: cosine piece (piece_0) and sine piece (piece_1)
// of a coupled-form resonator, each with a 1-bit sigma-delta output.
module sigma_delta_two_piece_top
  import sigma_delta_pkg::*;
#(
  parameter int                         FSIG     = 1000,
  parameter int                         BITWIDTH = DEF_BITWIDTH,
  parameter int                         KFRAC    = DEF_KFRAC,
  parameter logic signed [BITWIDTH-1:0] AMP      = BITWIDTH'(1) << (BITWIDTH-3),
  parameter logic signed [BITWIDTH+1:0] FS       = (BITWIDTH+2)'(1) << (BITWIDTH-2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BITWIDTH-1:0] kin,
  output logic [1:0]          sd_out
);

  logic signed [BITWIDTH-1:0] w_acc0_next;
  logic signed [BITWIDTH-1:0] w_acc1;
  logic                       w_sd0;
  logic                       w_sd1;

  if (FSIG <= 0 || BITWIDTH > MAXW || (BITWIDTH+2)'(AMP) >= FS) begin : g_bad_params
    $error("sigma_delta_two_piece_top: need FSIG > 0, BITWIDTH <= MAXW and AMP < FS");
  end

  sd_piece #(
    .BITWIDTH  (BITWIDTH),
    .KFRAC     (KFRAC),
    .INIT      (AMP),
    .SUBTRACT  (1'b1),
    .FEED_NEXT (1'b1),
    .FS        (FS)
  ) piece_0 (
    .clk    (clk),
    .reset  (reset),
    .i_kin  (kin),
    .i_mult (w_acc1),
    .o_feed (w_acc0_next),
    .o_sd   (w_sd0)
  );

  sd_piece #(
    .BITWIDTH  (BITWIDTH),
    .KFRAC     (KFRAC),
    .INIT      ('0),
    .SUBTRACT  (1'b0),
    .FEED_NEXT (1'b0),
    .FS        (FS)
  ) piece_1 (
    .clk    (clk),
    .reset  (reset),
    .i_kin  (kin),
    .i_mult (w_acc0_next),
    .o_feed (w_acc1),
    .o_sd   (w_sd1)
  );

  assign sd_out = {w_sd1, w_sd0};

endmodule

// File: tb/tb_sigma_delta_two_piece_top.sv
// Scoreboard bench for the two-piece sigma-delta oscillator.
module tb_sigma_delta_two_piece_top;

  localparam int BW = 40;
  localparam int KF = 32;
  localparam logic signed [BW-1:0] AMP    = 40'sh2000000000;
  localparam logic signed [BW+1:0] FS     = 42'sh04000000000;
  localparam longint               AMP_L  = 64'sd1 << 37;
  localparam longint               FS_L   = 64'sd1 << 38;
  localparam logic [BW-1:0]        K_ONE  = 40'h0100000000;
  localparam logic [BW-1:0]        K_TONE = 40'h000e2ce2c0;

  typedef struct {
    logic [1:0]             sd;
    logic signed [BW-1:0]   a0;
    logic signed [BW-1:0]   a1;
  } exp_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] kin   = '0;
  logic [1:0]    sd_out;

  int nChecks = 0;
  int nPassed = 0;

  logic signed [BW-1:0] mAcc0, mAcc1;
  logic signed [BW+1:0] mErr0, mErr1;
  logic [1:0]           mSd;
  exp_t                 q[$];

  logic signed [BW-1:0] tab0 [6];
  logic signed [BW-1:0] tab1 [6];

  sigma_delta_two_piece_top dut (
    .clk    (clk),
    .reset  (reset),
    .kin    (kin),
    .sd_out (sd_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPassed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic signed [BW-1:0] mulk(input logic [BW-1:0] k, input logic signed [BW-1:0] a);
    logic signed [127:0] kw;
    logic signed [127:0] aw;
    logic signed [127:0] p;
    kw = {88'd0, k};
    aw = a;
    p  = kw * aw;
    return p[BW+KF-1:KF];
  endfunction

  task automatic sdBit(input logic signed [BW-1:0] acc, inout logic signed [BW+1:0] err, output bit b);
    logic signed [BW+1:0] v;
    v   = err + acc;
    b   = (v >= 0);
    err = b ? v - FS : v + FS;
  endtask

  task automatic modelReset();
    mAcc0 = AMP;
    mAcc1 = '0;
    mErr0 = '0;
    mErr1 = '0;
    mSd   = 2'b00;
    q.delete();
  endtask

  // Drive one cycle of kin, predict the post-edge state, compare after the edge.
  task automatic applyStimulus(input logic [BW-1:0] k);
    exp_t e;
    logic signed [BW-1:0] g0, g1, n0, n1;
    bit b0, b1;
    kin = k;
    sdBit(mAcc0, mErr0, b0);
    sdBit(mAcc1, mErr1, b1);
    g0 = mulk(k, mAcc1);
    n0 = mAcc0 - g0;
    g1 = mulk(k, n0);
    n1 = mAcc1 + g1;
    mAcc0 = n0;
    mAcc1 = n1;
    mSd   = {b1, b0};
    e.sd = mSd;
    e.a0 = n0;
    e.a1 = n1;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    checkOutput("sd_out", sd_out, e.sd);
    checkOutput("acc0", dut.piece_0.acc, e.a0);
    checkOutput("acc1", dut.piece_1.acc, e.a1);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int ones;
    int firstCross, lastCross, nCross;
    longint peak, cur, prevA, sumAcc, diff, per10;
    logic signed [BW-1:0] before0;

    tab0 = '{AMP, '0, -AMP, -AMP, '0, AMP};
    tab1 = '{AMP, AMP, '0, -AMP, -AMP, '0};

    kin = K_ONE;
    modelReset();
    #1 reset = 1'b0;
    #11;
    checkOutput("rst_sd", sd_out, 2'b00);
    checkOutput("rst_acc0", dut.piece_0.acc, AMP);
    checkOutput("rst_acc1", dut.piece_1.acc, 40'sd0);
    checkOutput("rst_gained0", dut.piece_0.gained, 40'sd0);
    @(negedge clk);
    reset = 1'b1;

    // Frozen states: sine modulator toggles, cosine density 3/4.
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus('0);
      ones += int'(sd_out[0]);
      checkOutput("k0_sd1_alt", sd_out[1], (i % 2 == 0) ? 1 : 0);
    end
    checkOutput("k0_sd0_density", (ones >= 47 && ones <= 49) ? 1 : 0, 1);

    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(K_ONE);
      checkOutput("k1_tab_acc0", dut.piece_0.acc, tab0[i % 6]);
      checkOutput("k1_tab_acc1", dut.piece_1.acc, tab1[i % 6]);
    end
    for (int i = 0; i < 3; i++) applyStimulus(K_ONE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0);
      checkOutput("freeze_acc0", dut.piece_0.acc, tab0[2]);
      checkOutput("freeze_acc1", dut.piece_1.acc, tab1[2]);
      #3;
      checkOutput("freeze_sd_stable", sd_out, mSd);
    end

    // Asynchronous reset in the middle of a cycle while oscillating.
    for (int i = 0; i < 4; i++) applyStimulus(K_ONE);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_sd", sd_out, 2'b00);
    checkOutput("midrst_acc0", dut.piece_0.acc, AMP);
    checkOutput("midrst_acc1", dut.piece_1.acc, 40'sd0);
    checkOutput("midrst_gained0", dut.piece_0.gained, 40'sd0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(K_ONE);
      checkOutput("post_rst_acc0", dut.piece_0.acc, tab0[i % 6]);
      checkOutput("post_rst_acc1", dut.piece_1.acc, tab1[i % 6]);
    end

    // Long tone run: amplitude, period and modulator tracking.
    doReset();
    peak = 0; prevA = AMP_L; sumAcc = 0; ones = 0;
    firstCross = -1; lastCross = -1; nCross = 0;
    for (int i = 0; i < 20000; i++) begin
      before0 = mAcc0;
      applyStimulus(K_TONE);
      sumAcc += longint'(before0);
      ones += int'(sd_out[0]);
      cur = longint'(dut.piece_0.acc);
      if (cur < 0 && -cur > peak) peak = -cur;
      if (cur >= 0 && cur > peak) peak = cur;
      if (prevA < 0 && cur >= 0) begin
        if (firstCross < 0) firstCross = i;
        lastCross = i;
        nCross++;
      end
      prevA = cur;
    end
    checkOutput("tone_peak", (peak * 100 >= 99 * AMP_L && peak * 100 <= 101 * AMP_L) ? 1 : 0, 1);
    per10 = (nCross > 1) ? (longint'(lastCross - firstCross) * 10) / (nCross - 1) : 0;
    checkOutput("tone_period", (per10 >= 1125 && per10 <= 1145) ? 1 : 0, 1);
    diff = sumAcc - FS_L * (2 * longint'(ones) - 20000);
    checkOutput("tone_lowpass", (diff <= 2 * FS_L && diff >= -2 * FS_L) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/sigma_delta_two_piece_top.md
Name: sigma_delta_two_piece_top

Overview:
Quadrature digital oscillator with 1-bit sigma-delta outputs for tone generation. Two identical "pieces" each hold one integrator state of a modified coupled-form (magic-circle) resonator. The tuning word kin sets the tone frequency. Each piece drives a first-order sigma-delta modulator, giving a 2-bit output bus: bit 0 is the cosine channel, bit 1 is the sine channel.

Parameters:
FSIG, 1000, nominal tone frequency in Hz; documentation only, no logic depends on it.
BITWIDTH, 40, width of kin, integrator states and gained products (signed two's complement).
KFRAC, 32, fractional bits of kin (unsigned Q(BITWIDTH-KFRAC).KFRAC).
AMP, 2**(BITWIDTH-3), reset value of piece_0 state (oscillation amplitude).
FS, 2**(BITWIDTH-2), sigma-delta full-scale feedback magnitude; AMP < FS required.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
kin  input  BITWIDTH  unsigned tuning coefficient k; sampled live every cycle.
sd_out  output  2  [0] = sigma-delta bit of piece_0 (cos), [1] = sigma-delta bit of piece_1 (sin).

Behaviour:
- Reset (reset=0, async):
  - piece_0.acc = AMP, piece_1.acc = 0
  - both modulator error registers = 0
  - sd_out = 2'b00
- Per cycle (reset=1), k = kin:
  - piece_0.gained = (k * piece_1.acc) >>> KFRAC. Signed multiply with kin zero-extended; full-precision product, arithmetic shift, truncated to BITWIDTH bits. Combinational signal.
  - acc0_next = piece_0.acc - piece_0.gained
  - piece_1.gained = (k * acc0_next) >>> KFRAC, same rules. Uses the updated acc0; this keeps the amplitude bounded.
  - acc1_next = piece_1.acc + piece_1.gained
  - Both accs register on the edge. Adds and subtracts wrap at BITWIDTH bits; no saturation.
- Sigma-delta, per piece i, error register err_i is BITWIDTH+2 bits signed:
  - v = err_i + acc_i, using the registered acc before update.
  - sd_out[i] <= (v >= 0)
  - err_i <= v - (v >= 0 ? FS : -FS)
- Latency: a new acc value affects sd_out one cycle later; sd_out is registered with no combinational path from kin.
- Tone frequency θ satisfies 2·sin(θ/2) = kin/2**KFRAC, i.e. f = θ·fclk/(2π).
- kin = 0 freezes both states; the modulators keep running.
- Changing kin mid-run takes effect the next cycle; state is not reset, so phase is continuous.
- Asserting reset mid-run restores reset values immediately (async); the first update happens on the first clk edge after release.
- piece_0.gained and piece_1.gained must be real named nets inside instances named piece_0 and piece_1; debug dumps probe gained[BITWIDTH-1:8].

Decomposition:
- Package sigma_delta_pkg holds:
  - localparams for default BITWIDTH and KFRAC
  - function scale_mult(acc, k) returning the truncated shifted product
- Sub-module sd_piece, instantiated twice as piece_0 and piece_1, parameterized by INIT and a SUBTRACT flag. It contains:
  - the multiplier (gained)
  - the integrator
  - the sigma-delta modulator
- The top wires the acc0_next combinational output of piece_0 into piece_1's multiplier input.

Test Plan:
- Reset held, kin = any → sd_out = 00, piece_0.acc = AMP, piece_1.acc = 0, piece_0.gained = 0.
- kin = 0, 64 cycles after release:
  - sd_out[1] alternates 1,0,1,0…
  - sd_out[0] ones-density = 0.75 (AMP = FS/2) ±1/64
  - accs constant.
- kin = 2**32 (k = 1.0):
  - (acc0, acc1) cycles exactly (A,A), (0,A), (-A,0), (-A,-A), (0,-A), (A,0) with A = AMP.
  - Period is 6 cycles with no drift over 600 cycles.
- kin = 40'h000e2ce2c0, 20000 cycles:
  - acc0 peak magnitude stays within AMP ±1%.
  - Zero-crossing period ≈ 113.5 cycles.
  - Low-pass of sd_out[0] tracks acc0/FS.
- Change kin from 2**32 to 0 mid-run → accs freeze at the current values on the next edge; no glitch on sd_out.
- Assert reset mid-oscillation, asynchronously between edges → sd_out goes to 00 immediately and states reload; the post-release sequence matches the fresh-reset case.
